// File: rtl/gray_counter_updown.sv
// Up/down Gray-code counter with load, wrap or saturate mode.
// Keeps a binary count and registers its Gray image alongside it.
module gray_counter_updown #(
  parameter int DATA_WIDTH = 4,
  parameter bit SATURATE   = 1'b0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_val,
  output logic [DATA_WIDTH-1:0] out,
  output logic [DATA_WIDTH-1:0] bin_out,
  output logic                  term,
  output logic                  wrap
);

  localparam int W = DATA_WIDTH;
  localparam logic [W-1:0] MAX = '1;
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] bin_q, bin_d;
  logic [W-1:0] gray_q, gray_d;
  logic         wrap_q, wrap_d;
  logic         at_max, at_min;
  logic         step_up, step_dn;

  function automatic logic [W-1:0] g2b(
    input logic [W-1:0] g
  );
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // terminal detection for the direction currently requested
  always_comb begin
    at_max = (bin_q == MAX);
    at_min = (bin_q == '0);
    term   = up ? at_max : at_min;
  end

  // next count: load beats enable; saturate mode pins at the limit
  always_comb begin
    bin_d   = bin_q;
    wrap_d  = 1'b0;
    step_up = en && !load && up;
    step_dn = en && !load && !up;
    unique case (1'b1)
      load: begin
        bin_d = g2b(load_val);
      end
      step_up: begin
        if (!(SATURATE && at_max)) begin
          bin_d  = bin_q + ONE;
          wrap_d = at_max;
        end
      end
      step_dn: begin
        if (!(SATURATE && at_min)) begin
          bin_d  = bin_q - ONE;
          wrap_d = at_min;
        end
      end
      default: begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
      end
    endcase
    gray_d = bin_d ^ (bin_d >> 1);
  end

  // state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign out     = gray_q;
  assign bin_out = bin_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_gray_counter_updown.sv
// Directed bench for gray_counter_updown.
// Four instances: 4-bit wrap, 4-bit saturate, 2-bit and 8-bit wrap.
module tb_gray_counter_updown;

  logic clk = 1'b0;
  logic resetn, en, up, load;
  logic [3:0] lv4;
  logic [1:0] lv2;
  logic [7:0] lv8;

  logic [3:0] o4, b4, os, bs;
  logic [1:0] o2, b2;
  logic [7:0] o8, b8;
  logic t4, w4, ts, ws, t2, w2, t8, w8;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gray_counter_updown #(.DATA_WIDTH(4), .SATURATE(1'b0)) u_d4 (
    .clk(clk), .resetn(resetn), .en(en), .up(up), .load(load),
    .load_val(lv4), .out(o4), .bin_out(b4), .term(t4), .wrap(w4)
  );

  gray_counter_updown #(.DATA_WIDTH(4), .SATURATE(1'b1)) u_s4 (
    .clk(clk), .resetn(resetn), .en(en), .up(up), .load(load),
    .load_val(lv4), .out(os), .bin_out(bs), .term(ts), .wrap(ws)
  );

  gray_counter_updown #(.DATA_WIDTH(2), .SATURATE(1'b0)) u_d2 (
    .clk(clk), .resetn(resetn), .en(en), .up(up), .load(load),
    .load_val(lv2), .out(o2), .bin_out(b2), .term(t2), .wrap(w2)
  );

  gray_counter_updown #(.DATA_WIDTH(8), .SATURATE(1'b0)) u_d8 (
    .clk(clk), .resetn(resetn), .en(en), .up(up), .load(load),
    .load_val(lv8), .out(o8), .bin_out(b8), .term(t8), .wrap(w8)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    en = 1'b0; up = 1'b1; load = 1'b0;
    step();
    resetn = 1'b1;
  endtask

  logic [3:0] gtab [16];
  logic [3:0] prev4;
  logic [7:0] prev8;
  int bad8, nw2, nw8, wfirst8, wlast8, wgap2;
  int last2;

  initial begin
    gtab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
             4'b0110, 4'b0111, 4'b0101, 4'b0100,
             4'b1100, 4'b1101, 4'b1111, 4'b1110,
             4'b1010, 4'b1011, 4'b1001, 4'b1000};
    resetn = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0;
    lv4 = '0; lv2 = '0; lv8 = '0;

    // reset state
    do_reset();
    chk("rst_out", 32'(o4), 32'h0);
    chk("rst_bin", 32'(b4), 32'h0);
    chk("rst_wrap", 32'(w4), 32'h0);

    // full up sweep
    en = 1'b1; up = 1'b1;
    prev4 = o4;
    for (int i = 1; i <= 17; i++) begin
      step();
      chk($sformatf("up_out%0d", i), 32'(o4), 32'(gtab[i % 16]));
      chk($sformatf("up_bin%0d", i), 32'(b4), 32'(i % 16));
      chk($sformatf("up_wrap%0d", i), 32'(w4), 32'(i == 16));
      chk($sformatf("up_term%0d", i), 32'(t4), 32'(i % 16 == 15));
      chk($sformatf("up_ham%0d", i), $countones(prev4 ^ o4), 32'd1);
      prev4 = o4;
    end

    // down wrap
    do_reset();
    up = 1'b0;
    #1;
    chk("dn_term0", 32'(t4), 32'h1);
    en = 1'b1;
    step();
    chk("dn_out1", 32'(o4), 32'b1000);
    chk("dn_bin1", 32'(b4), 32'd15);
    chk("dn_wrap1", 32'(w4), 32'h1);
    chk("dn_term1", 32'(t4), 32'h0);
    step();
    chk("dn_out2", 32'(o4), 32'b1001);
    chk("dn_bin2", 32'(b4), 32'd14);
    chk("dn_wrap2", 32'(w4), 32'h0);
    step();
    chk("dn_out3", 32'(o4), 32'b1011);
    chk("dn_bin3", 32'(b4), 32'd13);

    // load clears a pending wrap
    do_reset();
    en = 1'b1; up = 1'b0;
    step();
    chk("lw_wrap", 32'(w4), 32'h1);
    load = 1'b1; lv4 = 4'b1000;
    step();
    chk("lw_clr", 32'(w4), 32'h0);
    chk("lw_out", 32'(o4), 32'b1000);

    // load priority over en
    do_reset();
    load = 1'b1; en = 1'b1; up = 1'b0; lv4 = 4'b1101;
    step();
    chk("ld_out", 32'(o4), 32'b1101);
    chk("ld_bin", 32'(b4), 32'd9);
    load = 1'b0; up = 1'b1;
    step();
    chk("ld_inc", 32'(o4), 32'b1111);
    chk("ld_incb", 32'(b4), 32'd10);
    load = 1'b1; resetn = 1'b0;
    step();
    chk("ld_rst", 32'(o4), 32'h0);
    chk("ld_rstb", 32'(b4), 32'h0);

    // saturate at MAX
    do_reset();
    load = 1'b1; lv4 = 4'b1000; en = 1'b1; up = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("sat_hi_out%0d", i), 32'(os), 32'b1000);
      chk($sformatf("sat_hi_term%0d", i), 32'(ts), 32'h1);
      chk($sformatf("sat_hi_wrap%0d", i), 32'(ws), 32'h0);
    end
    up = 1'b0;
    step();
    chk("sat_hi_back", 32'(os), 32'b1001);
    chk("sat_hi_bin", 32'(bs), 32'd14);

    // saturate at 0
    load = 1'b1; lv4 = 4'b0000;
    step();
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("sat_lo_out%0d", i), 32'(os), 32'h0);
      chk($sformatf("sat_lo_term%0d", i), 32'(ts), 32'h1);
      chk($sformatf("sat_lo_wrap%0d", i), 32'(ws), 32'h0);
    end
    up = 1'b1;
    step();
    chk("sat_lo_back", 32'(os), 32'b0001);

    // hold and mid-count reset
    do_reset();
    en = 1'b1; up = 1'b1;
    repeat (4) step();
    chk("hold_pre", 32'(o4), 32'b0110);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("hold%0d", i), 32'(o4), 32'b0110);
    end
    en = 1'b1; resetn = 1'b0;
    step();
    chk("mid_rst", 32'(o4), 32'h0);
    chk("mid_rst_w", 32'(w4), 32'h0);
    resetn = 1'b1;
    step();
    chk("resume", 32'(o4), 32'b0001);

    // width sweep
    do_reset();
    en = 1'b1; up = 1'b1;
    prev8 = o8;
    bad8 = 0; nw2 = 0; nw8 = 0; wfirst8 = 0; wlast8 = 0;
    wgap2 = 0; last2 = 0;
    for (int i = 1; i <= 512; i++) begin
      step();
      if ($countones(prev8 ^ o8) != 1) bad8++;
      prev8 = o8;
      if (w2) begin
        if (i - last2 != 4) wgap2++;
        last2 = i;
        nw2++;
      end
      if (w8) begin
        if (nw8 == 0) wfirst8 = i;
        wlast8 = i;
        nw8++;
      end
      if (i == 255) begin
        chk("w8_max", 32'(o8), 32'h80);
        chk("w8_maxb", 32'(b8), 32'd255);
        chk("w8_term", 32'(t8), 32'h1);
      end
      if (i == 3) chk("w2_max", 32'(o2), 32'b10);
    end
    chk("w2_count", nw2, 32'd128);
    chk("w2_gap", wgap2, 32'd0);
    chk("w8_count", nw8, 32'd2);
    chk("w8_first", wfirst8, 32'd256);
    chk("w8_last", wlast8, 32'd512);
    chk("w8_ham", bad8, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/gray_counter_updown.md
Name: gray_counter_updown

Overview:
- Parametrised Gray-code counter with enable, up/down direction, parallel load and a selectable wrap or saturate mode.
- Next-generation replacement for the fixed up-only Gray counter. Used for async-FIFO pointers and low-toggle position counters.
- Provides registered Gray output, matching binary output, a terminal-count flag and a wrap pulse.

Parameters:
- DATA_WIDTH, 4, counter width in bits; legal range is 2 or more.
- SATURATE, 0. 0 means the count wraps modulo 2^DATA_WIDTH. 1 means the count holds at the terminal value.

Ports:
- clk  input  1  clock, rising edge.
- resetn  input  1  synchronous reset, active-low.
- en  input  1  advance the count by one Gray step this cycle.
- up  input  1  direction: 1 counts up, 0 counts down. Sampled with en.
- load  input  1  parallel load; has priority over en.
- load_val  input  DATA_WIDTH  Gray-coded value to load.
- out  output  DATA_WIDTH  current Gray-code count (registered).
- bin_out  output  DATA_WIDTH  binary equivalent of out (registered, same cycle as out).
- term  output  1  combinational: high when the count is at the terminal value for the current up input.
- wrap  output  1  one-cycle registered pulse on a wrap-around.

Behaviour:
- Clocking and reset
  - All state updates on the rising edge of clk. Clock is clk; reset is resetn, synchronous, active-low.
  - resetn=0 at an edge sets out=0, bin_out=0, wrap=0. Reset overrides load and en, including mid-count.
- State
  - Internal state is a binary count B.
  - out = B ^ (B >> 1), registered together with B, so out and bin_out change on the same edge.
  - No extra latency: an en at edge k shows the new value immediately after edge k.
- Priority per edge (resetn=1)
  - load=1: B <= gray_to_bin(load_val), where bit i of B is the XOR of load_val bits DATA_WIDTH-1 down to i. wrap <= 0. en and up are ignored.
  - Else en=1, up=1: B <= B+1 (modulo 2^DATA_WIDTH).
  - Else en=1, up=0: B <= B-1 (modulo 2^DATA_WIDTH).
  - Else: hold; wrap <= 0.
- Terminal values
  - MAX is binary all-ones; Gray 1 followed by zeros (for example 1000 at width 4).
  - MIN is 0.
  - term = up ? (B==MAX) : (B==0).
- SATURATE=0
  - Counting up from MAX gives 0 with wrap=1 for exactly one cycle, coincident with out=0.
  - Counting down from 0 gives MAX with wrap=1 for one cycle.
  - Otherwise wrap=0.
- SATURATE=1
  - en while term=1 holds B; wrap is never asserted.
  - en with the opposite direction still moves away from the limit normally.
- Invariant: every en step that changes out (no load, no reset) changes exactly one bit of out.
- Direction change between consecutive enabled cycles is legal. The count reverses immediately with no bubble.
- load_val may be any Gray value, including MAX. A load while at a terminal value clears any pending wrap.

Test Plan:
- Full up sweep, W=4, SATURATE=0: reset, then en=1, up=1 for 17 cycles. out must step 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000. bin_out must run 0..15,0. wrap=1 only on the cycle out returns to 0000. The checker verifies Hamming distance 1 between successive values.
- Down wrap: from reset, en=1, up=0 for 3 cycles. out must be 1000 (bin 15, wrap=1), then 1001 (14), then 1011 (13). term=1 with up=0 only while out=0000.
- Load and priority: load=1, en=1, load_val=1101 -> out=1101, bin_out=1001 (9). Next cycle en=1, up=1 -> out=1111 (10). A load asserted together with resetn=0 -> out=0000.
- Saturate, SATURATE=1: load 1000 (MAX), en=1, up=1 for 3 cycles -> out stays 1000, term=1, wrap=0. Then up=0 for one cycle -> out=1001 (14). Repeat the check at 0 counting down.
- Hold and mid-count reset: count to out=0110, drop en for 4 cycles -> out holds 0110. Pulse resetn=0 for 1 cycle during en=1 -> out=0000, wrap=0. Counting resumes at 0001 on the first enabled edge after release.
- Width sweep: DATA_WIDTH=2 and 8, full up cycle. Wrap period must be 4 and 256 enabled cycles. The 8-bit MAX out must be 10000000.
